multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the CPU core.
- Sequences fetch, decode, execute, memory and writeback for a MIPS subset.
- Drives all datapath strobes, including the select of the 5-bit register write-address mux (rt vs rd field).
- Handshakes with a variable-latency memory and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter
HALT_OP, 6'h3F, opcode that stops the core

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
opcode  input  6  IR[31:26], valid from ID onward
funct  input  6  IR[5:0]
alu_zero  input  1  ALU zero flag, sampled in EX
mem_ready  input  1  memory access complete this cycle
pc_we  output  1  PC write enable
pc_src  output  2  00 ALU result, 01 branch target, 10 jump target
ir_we  output  1  instruction register load
mem_re  output  1  memory read request
mem_we  output  1  memory write request
reg_we  output  1  register file write enable
wr_addr_sel  output  1  write-address mux select: 1 = rt field, 0 = rd field
mem_to_reg  output  1  1 = writeback data from memory, 0 = from ALU
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 zero-ext imm
alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
state  output  3  current state encoding
halted  output  1  core stopped
illegal  output  1  sticky: undecodable instruction seen
instr_cnt  output  CNT_W  retired instruction count

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset effect: state=IF, instr_cnt=0, illegal=0, halted=0, latched op/funct=0.
- All strobes (pc_we, ir_we, mem_re, mem_we, reg_we) are forced 0 while reset is high.
- Reset mid-operation aborts the instruction with no partial strobe; the first cycle after release is IF.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Other values go to IF on the next edge.
- Default outputs: every output not listed for a state is 0.
- IF:
  - mem_re=1, alu_src_a=0, alu_src_b=01, alu_op=add.
  - Stay in IF while mem_ready=0.
  - On mem_ready=1, in the same cycle: ir_we=1, pc_we=1, pc_src=00; next state ID.
- ID:
  - Latch opcode/funct into internal registers.
  - Decode: R-type op 00 with funct 20 add / 22 sub / 24 and / 25 or / 2A slt; addi 08; ori 0D; lw 23; sw 2B; beq 04; j 02; HALT_OP.
  - Legal, not halt: next state EX.
  - HALT_OP: next state HALT.
  - Anything else: illegal<=1, next state HALT.
- EX (alu_src_a=1):
  - R-type: alu_src_b=00, alu_op from funct; next WB.
  - addi: src_b=10, add; next WB.
  - ori: src_b=11, or; next WB.
  - lw/sw: src_b=10, add; next MEM.
  - beq: src_b=00, sub; pc_we=alu_zero, pc_src=01; instr_cnt+1; next IF.
  - j: pc_we=1, pc_src=10; instr_cnt+1; next IF.
- MEM:
  - lw: mem_re=1. sw: mem_we=1.
  - Strobe is held until mem_ready=1.
  - On mem_ready: lw goes to WB; sw increments instr_cnt and goes to IF.
- WB:
  - reg_we=1 for one cycle; instr_cnt+1; next IF.
  - wr_addr_sel=0 for R-type, 1 for addi/ori/lw.
  - mem_to_reg=1 only for lw.
- HALT:
  - halted=1, all strobes 0.
  - Stays in HALT until reset.
  - illegal is held.
- instr_cnt wraps from all-ones to 0 silently.
- Simultaneous events: mem_ready and reset together means reset wins.
- mem_ready outside IF/MEM is ignored.
- Latency per instruction class:
  - j, beq: 3 cycles + fetch wait.
  - R-type, addi, ori: 4 cycles + fetch wait.
  - sw: 4 cycles + fetch and memory waits.
  - lw: 5 cycles + fetch and memory waits.

Test Plan:
- Reset asserted mid-MEM with mem_we=1 -> mem_we drops asynchronously, state=0, instr_cnt=0; first post-release cycle shows mem_re=1.
- add (op 00, funct 20), mem_ready=1 in IF -> state sequence 0,1,2,4,0; in WB reg_we=1, wr_addr_sel=0, mem_to_reg=0; instr_cnt=1.
- lw (op 23), mem_ready low for 3 cycles in MEM -> mem_re held 4 cycles; WB has wr_addr_sel=1, mem_to_reg=1; 5 active states total.
- beq (op 04): alu_zero=1 -> pc_we=1 with pc_src=01 in EX; alu_zero=0 -> pc_we=0; both runs return to IF and count +1.
- opcode 3E -> illegal=1, halted=1, state=5; state and strobes stay frozen 20 cycles despite mem_ready toggling; reset clears both flags.
- CNT_W=4, 16 consecutive j instructions -> instr_cnt goes 15 then 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a MIPS-subset core.
// Sequences IF/ID/EX/MEM/WB, drives datapath strobes, waits on a
// variable-latency memory and counts retired instructions.
module multicycle_ctrl #(
    parameter int          CNT_W   = 16,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             wr_addr_sel,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    logic [2:0] next_state;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic       cnt_inc;
    logic       id_legal;

    function automatic logic rtype_ok(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) ||
               (f == 6'h25) || (f == 6'h2A);
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'h22:   return 3'b001;
            6'h24:   return 3'b010;
            6'h25:   return 3'b011;
            6'h2A:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Decode legality of the instruction presented during ID
    always_comb begin
        case (opcode)
            OP_RTYPE: id_legal = rtype_ok(funct);
            OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: id_legal = 1'b1;
            default:  id_legal = 1'b0;
        endcase
    end

    // Next-state and datapath strobe generation; strobes masked during reset
    always_comb begin
        next_state  = state;
        cnt_inc     = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        ir_we       = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        wr_addr_sel = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 3'b000;
        halted      = 1'b0;
        case (state)
            S_IF: begin
                mem_re    = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    next_state = S_ID;
                end
            end
            S_ID: begin
                if (opcode == HALT_OP)  next_state = S_HALT;
                else if (id_legal)      next_state = S_EX;
                else                    next_state = S_HALT;
            end
            S_EX: begin
                alu_src_a  = 1'b1;
                next_state = S_IF;
                case (op_q)
                    OP_RTYPE: begin
                        alu_op     = rtype_alu(funct_q);
                        next_state = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src_b  = 2'b10;
                        next_state = S_WB;
                    end
                    OP_ORI: begin
                        alu_src_b  = 2'b11;
                        alu_op     = 3'b011;
                        next_state = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b  = 2'b10;
                        next_state = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op  = 3'b001;
                        pc_we   = alu_zero;
                        pc_src  = 2'b01;
                        cnt_inc = 1'b1;
                    end
                    OP_J: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'b10;
                        cnt_inc = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LW) mem_re = 1'b1;
                else               mem_we = 1'b1;
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        next_state = S_WB;
                    end else begin
                        cnt_inc    = 1'b1;
                        next_state = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_we      = 1'b1;
                wr_addr_sel = (op_q != OP_RTYPE);
                mem_to_reg  = (op_q == OP_LW);
                cnt_inc     = 1'b1;
                next_state  = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next_state = S_IF;
        endcase
        // state already reads IF under reset, so the IF strobes must be killed here
        if (reset) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            mem_re  = 1'b0;
            mem_we  = 1'b0;
            reg_we  = 1'b0;
            cnt_inc = 1'b0;
        end
    end

    // State, latched instruction fields, sticky illegal flag and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IF;
            op_q      <= '0;
            funct_q   <= '0;
            illegal   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_ID) begin
                op_q    <= opcode;
                funct_q <= funct;
                if (opcode != HALT_OP && !id_legal) illegal <= 1'b1;
            end
            if (cnt_inc) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-instruction expected cycle traces built
// from the instruction class, compared against the DUT every cycle.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    localparam int C_R    = 0;
    localparam int C_ADDI = 1;
    localparam int C_ORI  = 2;
    localparam int C_LW   = 3;
    localparam int C_SW   = 4;
    localparam int C_BEQ  = 5;
    localparam int C_J    = 6;
    localparam int C_HALT = 7;
    localparam int C_ILL  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          alu_zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_we;
    logic [1:0]    pc_src;
    logic          ir_we;
    logic          mem_re;
    logic          mem_we;
    logic          reg_we;
    logic          wr_addr_sel;
    logic          mem_to_reg;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_op;
    logic [2:0]    state;
    logic          halted;
    logic          illegal;
    logic [CW-1:0] instr_cnt;

    multicycle_ctrl #(.CNT_W(CW), .HALT_OP(6'h3F)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_we(pc_we),
        .pc_src(pc_src), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we),
        .reg_we(reg_we), .wr_addr_sel(wr_addr_sel), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic          pc_we;
        logic [1:0]    pc_src;
        logic          ir_we;
        logic          mem_re;
        logic          mem_we;
        logic          reg_we;
        logic          wr_addr_sel;
        logic          mem_to_reg;
        logic          alu_src_a;
        logic [1:0]    alu_src_b;
        logic [2:0]    alu_op;
        logic          halted;
        logic          illegal;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_v;
    exp_t act_v;
    logic exp_valid = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   m_cnt = 0;
    logic m_ill = 1'b0;

    assign act_v = {state, pc_we, pc_src, ir_we, mem_re, mem_we, reg_we,
                    wr_addr_sel, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    halted, illegal, instr_cnt};

    // Model comparison on every active cycle, away from the rising edge
    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_trace t=%0t actual=%h required=%h (state act=%0d req=%0d)",
                         $time, act_v, exp_v, state, exp_v.st);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic lit(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, a, e);
        end
    endtask

    function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                           fn == 6'h25 || fn == 6'h2A) ? C_R : C_ILL;
            6'h08: return C_ADDI;
            6'h0D: return C_ORI;
            6'h23: return C_LW;
            6'h2B: return C_SW;
            6'h04: return C_BEQ;
            6'h02: return C_J;
            6'h3F: return C_HALT;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] r_aluop(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'd0;
            6'h22: return 3'd1;
            6'h24: return 3'd2;
            6'h25: return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    function automatic exp_t base(input int st);
        exp_t e;
        e = '0;
        e.st      = 3'(st);
        e.halted  = (st == 5);
        e.illegal = m_ill;
        e.cnt     = CW'(m_cnt % (1 << CW));
        return e;
    endfunction

    task automatic cyc(input exp_t e, input logic mr, input logic z);
        mem_ready = mr;
        alu_zero  = z;
        exp_v     = e;
        exp_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int fw);
        exp_t e;
        e = base(0);
        e.mem_re = 1'b1;
        e.alu_src_b = 2'b01;
        for (int i = 0; i < fw; i++) cyc(e, 1'b0, 1'($urandom));
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
        cyc(e, 1'b1, 1'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_valid = 1'b0;
        #1;
        lit("rst_state", state, 0);
        lit("rst_strobes", {pc_we, ir_we, mem_re, mem_we, reg_we}, 0);
        lit("rst_cnt", instr_cnt, 0);
        lit("rst_flags", {illegal, halted}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cnt = 0;
        m_ill = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z);
        exp_t e;
        int c;
        c = cls(op, fn);
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        fetch(fw);
        opcode = op;
        funct  = fn;
        cyc(base(1), 1'($urandom), 1'($urandom));
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        if (c == C_HALT || c == C_ILL) begin
            if (c == C_ILL) m_ill = 1'b1;
            for (int i = 0; i < 20; i++) cyc(base(5), 1'($urandom), 1'($urandom));
            return;
        end
        e = base(2);
        e.alu_src_a = 1'b1;
        case (c)
            C_R:          e.alu_op = r_aluop(fn);
            C_ADDI:       e.alu_src_b = 2'b10;
            C_ORI:        begin e.alu_src_b = 2'b11; e.alu_op = 3'd3; end
            C_LW, C_SW:   e.alu_src_b = 2'b10;
            C_BEQ:        begin e.alu_op = 3'd1; e.pc_we = z; e.pc_src = 2'b01; end
            default:      begin e.pc_we = 1'b1; e.pc_src = 2'b10; end
        endcase
        cyc(e, 1'($urandom), (c == C_BEQ) ? z : 1'($urandom));
        if (c == C_BEQ || c == C_J) begin
            m_cnt++;
            return;
        end
        if (c == C_LW || c == C_SW) begin
            e = base(3);
            if (c == C_LW) e.mem_re = 1'b1;
            else           e.mem_we = 1'b1;
            for (int i = 0; i < mw; i++) cyc(e, 1'b0, 1'($urandom));
            cyc(e, 1'b1, 1'($urandom));
            if (c == C_SW) begin
                m_cnt++;
                return;
            end
        end
        e = base(4);
        e.reg_we      = 1'b1;
        e.wr_addr_sel = (c != C_R);
        e.mem_to_reg  = (c == C_LW);
        cyc(e, 1'($urandom), 1'($urandom));
        m_cnt++;
    endtask

    logic [5:0] op_tab [0:8];
    logic [5:0] fn_tab [0:4];

    initial begin
        exp_t e;
        op_tab = '{6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h00};
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        @(posedge clk);
        #1;
        do_reset();

        // add: 0,1,2,4,0 and one retirement
        run_instr(6'h00, 6'h20, 0, 0, 1'b0);
        lit("add_cnt", instr_cnt, 1);
        lit("add_back_to_if", state, 0);

        // lw with three memory wait cycles
        run_instr(6'h23, 6'h11, 1, 3, 1'b0);
        lit("lw_cnt", instr_cnt, 2);

        // beq taken and not taken
        run_instr(6'h04, 6'h00, 0, 0, 1'b1);
        lit("beq_taken_cnt", instr_cnt, 3);
        run_instr(6'h04, 6'h00, 2, 0, 1'b0);
        lit("beq_not_taken_cnt", instr_cnt, 4);

        // reset in the middle of a sw memory wait
        opcode = 6'h2B;
        fetch(0);
        cyc(base(1), 1'b0, 1'b0);
        e = base(2);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        cyc(e, 1'b0, 1'b0);
        e = base(3);
        e.mem_we = 1'b1;
        cyc(e, 1'b0, 1'b0);
        lit("mid_mem_we_before", mem_we, 1);
        lit("mid_mem_cnt_before", instr_cnt, 4);
        reset = 1'b1;
        exp_valid = 1'b0;
        #1;
        lit("mid_mem_we_async_drop", mem_we, 0);
        lit("mid_mem_state_async", state, 0);
        do_reset();
        #1;
        lit("post_release_mem_re", mem_re, 1);
        run_instr(6'h08, 6'h00, 1, 0, 1'b0);
        lit("post_release_addi_cnt", instr_cnt, 1);

        // undecodable opcode 3E halts and sets illegal
        run_instr(6'h3E, 6'h00, 0, 0, 1'b0);
        lit("ill_flag", illegal, 1);
        lit("ill_halted", halted, 1);
        lit("ill_state", state, 5);
        do_reset();

        // counter wrap with a 4-bit counter
        for (int i = 0; i < 15; i++) run_instr(6'h02, 6'($urandom), 0, 0, 1'b0);
        lit("wrap_cnt_15", instr_cnt, 15);
        run_instr(6'h02, 6'h00, 0, 0, 1'b0);
        lit("wrap_cnt_0", instr_cnt, 0);

        // random instruction stream
        for (int n = 0; n < 300; n++) begin
            int k;
            logic [5:0] op;
            logic [5:0] fn;
            k  = ($urandom_range(0, 19) == 0) ? 7 : int'($urandom_range(0, 6));
            op = op_tab[k];
            fn = fn_tab[$urandom_range(0, 4)];
            if ($urandom_range(0, 24) == 0) op = 6'($urandom);
            if (op == 6'h00 && $urandom_range(0, 24) == 0) fn = 6'($urandom);
            run_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom));
            if (cls(op, fn) == C_HALT || cls(op, fn) == C_ILL) do_reset();
        end

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
